// File: rtl/flash_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// flash_bus_arb_pkg
// Shared definitions for the parallel NOR flash read arbiter:
//   - flash address / data widths
//   - default access and recovery timing (in clk cycles)
//   - read-sequencer state encoding
//   - helper that sizes the timing counter
// -----------------------------------------------------------------------------
package flash_bus_arb_pkg;

    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 16;
    localparam int DEF_T_ACC  = 6;
    localparam int DEF_T_HOLD = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    // Counter must hold the largest of the two phase lengths without wrapping.
    function automatic int cnt_width(input int t_acc, input int t_hold);
        int m;
        m = (t_acc > t_hold) ? t_acc : t_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/flash_bus_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// flash_rr_arb2
// Combinational two-input round-robin arbiter. The pointer register lives in
// the parent; this block only decides.
//   req_i   [1:0] : request levels, bit N = requester N
//   last_i        : requester served most recently (loses a tie)
//   grant_o [1:0] : one-hot grant, 2'b00 when nobody requests
// -----------------------------------------------------------------------------
module flash_rr_arb2
    import flash_bus_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // One-hot grant: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/flash_bus_arb.sv
// -----------------------------------------------------------------------------
// flash_bus_arb
// Round-robin arbiter and timed asynchronous read sequencer for the shared
// parallel NOR flash bus. One read cycle per grant:
//   IDLE -> SETUP (address only) -> ACCESS (CE#/OE# low T_ACC cycles, capture
//   on last) -> RECOVER (strobes high, address held T_HOLD cycles) -> IDLE.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rqN_req / rqN_addr       : request level and word address of requester N
//   rqN_ack                  : one-cycle pulse, address accepted
//   rqN_rdata / rqN_valid    : captured data, valid one-cycle pulse
//   fl_cen/fl_oen/fl_wen     : active-low flash strobes (WE# always high)
//   fl_a                     : flash word address
//   fl_d_in                  : flash data from the pad
//   fl_bus_en                : pad drive enable, 0 releases the pins
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module flash_bus_arb
    import flash_bus_arb_pkg::*;
#(
    parameter int T_ACC  = DEF_T_ACC,
    parameter int T_HOLD = DEF_T_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_req,
    input  logic [ADDR_W-1:0] rq0_addr,
    output logic              rq0_ack,
    output logic [DATA_W-1:0] rq0_rdata,
    output logic              rq0_valid,
    input  logic              rq1_req,
    input  logic [ADDR_W-1:0] rq1_addr,
    output logic              rq1_ack,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              rq1_valid,
    output logic              fl_cen,
    output logic              fl_oen,
    output logic              fl_wen,
    output logic [ADDR_W-1:0] fl_a,
    input  logic [DATA_W-1:0] fl_d_in,
    output logic              fl_bus_en
);

    localparam int            CW        = cnt_width(T_ACC, T_HOLD);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] ACC_LAST  = CW'(T_ACC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(T_HOLD - 1);

    state_e              state_q,  state_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic                ptr_q,    ptr_d;     // requester preferred on a tie
    logic                gnt_q,    gnt_d;     // requester owning the current cycle
    logic                cen_q,    cen_d;
    logic                oen_q,    oen_d;
    logic                wen_q;
    logic                bus_en_q, bus_en_d;
    logic [ADDR_W-1:0]   fl_a_q,   fl_a_d;
    logic                ack0_q,   ack0_d;
    logic                ack1_q,   ack1_d;
    logic                valid0_q, valid0_d;
    logic                valid1_q, valid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic [1:0]          req_s;
    logic [1:0]          grant_s;

    assign req_s = {rq1_req, rq0_req};

    // The arbiter wants the last-served requester, i.e. the one not preferred.
    flash_rr_arb2 u_arb (
        .req_i   (req_s),
        .last_i  (~ptr_q),
        .grant_o (grant_s)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            cen_q    <= 1'b1;
            oen_q    <= 1'b1;
            wen_q    <= 1'b1;
            bus_en_q <= 1'b0;
            fl_a_q   <= {ADDR_W{1'b0}};
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            rdata0_q <= {DATA_W{1'b0}};
            rdata1_q <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cen_q    <= cen_d;
            oen_q    <= oen_d;
            wen_q    <= 1'b1;
            bus_en_q <= bus_en_d;
            fl_a_q   <= fl_a_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state logic of the read sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != 2'b00) state_d = ST_SETUP;
                else                  state_d = ST_IDLE;
            end
            ST_SETUP:   state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (cnt_q == ACC_LAST) state_d = ST_RECOVER;
                else                   state_d = ST_ACCESS;
            end
            ST_RECOVER: begin
                if (cnt_q == HOLD_LAST) state_d = ST_IDLE;
                else                    state_d = ST_RECOVER;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of counter, pointer, strobes, handshakes and read data.
    always_comb begin
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        cen_d    = cen_q;
        oen_d    = oen_q;
        bus_en_d = bus_en_q;
        fl_a_d   = fl_a_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                cen_d = 1'b1;
                oen_d = 1'b1;
                cnt_d = CNT_ZERO;
                if (grant_s != 2'b00) begin
                    gnt_d    = grant_s[1];
                    ptr_d    = ~grant_s[1];
                    fl_a_d   = grant_s[1] ? rq1_addr : rq0_addr;
                    ack0_d   = grant_s[0];
                    ack1_d   = grant_s[1];
                    bus_en_d = 1'b1;
                end else begin
                    bus_en_d = 1'b0;
                end
            end
            ST_SETUP: begin
                // Address has had one cycle of setup; drop both strobes together.
                cen_d = 1'b0;
                oen_d = 1'b0;
                cnt_d = CNT_ZERO;
            end
            ST_ACCESS: begin
                if (cnt_q == ACC_LAST) begin
                    // Capture on the same edge that raises the strobes.
                    cen_d = 1'b1;
                    oen_d = 1'b1;
                    cnt_d = CNT_ZERO;
                    if (gnt_q) begin
                        rdata1_d = fl_d_in;
                        valid1_d = 1'b1;
                    end else begin
                        rdata0_d = fl_d_in;
                        valid0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == HOLD_LAST) begin
                    bus_en_d = 1'b0;
                    cnt_d    = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cen_d    = 1'b1;
                oen_d    = 1'b1;
                bus_en_d = 1'b0;
                cnt_d    = CNT_ZERO;
            end
        endcase
    end

    assign rq0_ack   = ack0_q;
    assign rq1_ack   = ack1_q;
    assign rq0_valid = valid0_q;
    assign rq1_valid = valid1_q;
    assign rq0_rdata = rdata0_q;
    assign rq1_rdata = rdata1_q;
    assign fl_cen    = cen_q;
    assign fl_oen    = oen_q;
    assign fl_wen    = wen_q;
    assign fl_a      = fl_a_q;
    assign fl_bus_en = bus_en_q;

endmodule
